x_top_uart_rx_cfg: RTL and testbench

X_TOP_UART_RX_CFG -- requirements
Module: x_top_uart_rx_cfg

---
 rtl/x_uart_pkg.sv | 21 ++
 rtl/x_uart_rx_filter.sv | 30 +++
 rtl/x_top_uart_rx_cfg.sv | 158 +++++++++++++++
 tb/tb_x_top_uart_rx_cfg.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/x_uart_pkg.sv
// Shared UART receive definitions: parity-mode codes, receiver states, majority vote.
// Pure declarations; no timing, no flow control.
package x_uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    function automatic logic maj3(input logic [2:0] h);
        return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
    endfunction

endpackage

// File: rtl/x_uart_rx_filter.sv
// Two-flop line synchroniser with a 3-sample history; emits majority bit and falling-edge strobe.
// Latency: 3 cycles from i_rx to history; no backpressure.
module x_uart_rx_filter
    import x_uart_pkg::*;
(
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_rx,
    output logic o_bit,
    output logic o_fall
);

    logic [1:0] sync_q;
    logic [2:0] hist_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            sync_q <= 2'b11;
            hist_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[0], i_rx};
            hist_q <= {hist_q[1:0], sync_q[1]};
        end
    end

    // hist_q[0] is the newest synchronised sample
    assign o_bit  = maj3(hist_q);
    assign o_fall = hist_q[1] & ~hist_q[0];

endmodule

// File: rtl/x_top_uart_rx_cfg.sv
// Configurable UART receiver (5..9 data bits, none/even/odd parity, 1..2 stop bits).
// Result registered one cycle after the last stop sample; no backpressure, o_valid is a single pulse.
module x_top_uart_rx_cfg
    import x_uart_pkg::*;
#(
    parameter int P_CLK_HZ    = 1000000,
    parameter int P_BAUD      = 9600,
    parameter int P_DATA_BITS = 8,
    parameter int P_PARITY    = 0,
    parameter int P_STOP_BITS = 1
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic                   i_rx,
    output logic                   o_valid,
    output logic [P_DATA_BITS-1:0] o_data,
    output logic                   o_parity_err,
    output logic                   o_frame_err,
    output logic                   o_busy
);

    localparam int P  = P_CLK_HZ / P_BAUD;
    localparam int H  = P / 2;
    localparam int TW = $clog2(P);

    localparam logic [TW-1:0] T_HALF    = TW'(H - 1);
    localparam logic [TW-1:0] T_FULL    = TW'(P - 1);
    localparam logic [3:0]    LAST_DATA = 4'(P_DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(P_STOP_BITS - 1);

    logic rx_bit;
    logic rx_fall;

    x_uart_rx_filter u_filter (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_rx   (i_rx),
        .o_bit  (rx_bit),
        .o_fall (rx_fall)
    );

    rx_state_e              state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [P_DATA_BITS-1:0] shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   valid_q, valid_d;
    logic [P_DATA_BITS-1:0] data_q, data_d;
    logic                   operr_q, operr_d;
    logic                   oferr_q, oferr_d;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            operr_q <= 1'b0;
            oferr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            operr_q <= operr_d;
            oferr_q <= oferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        valid_d = 1'b0;
        data_d  = data_q;
        operr_d = operr_q;
        oferr_d = oferr_q;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (rx_fall) state_d = ST_START;
            end
            ST_START: begin
                // mid-start check rejects glitches shorter than half a bit
                if (timer_q == T_HALF) begin
                    timer_d = '0;
                    if (!rx_bit) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    shift_d = {rx_bit, shift_q[P_DATA_BITS-1:1]};
                    if (cnt_q == LAST_DATA) begin
                        cnt_d   = '0;
                        state_d = (P_PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    perr_d  = (P_PARITY == PAR_EVEN) ? (^shift_q ^ rx_bit) : ~(^shift_q ^ rx_bit);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    ferr_d  = ferr_q | ~rx_bit;
                    if (cnt_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        operr_d = perr_q;
                        oferr_d = ferr_q | ~rx_bit;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign o_valid      = valid_q;
    assign o_data       = data_q;
    assign o_parity_err = operr_q;
    assign o_frame_err  = oferr_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_x_top_uart_rx_cfg.sv
// Bench for x_top_uart_rx_cfg: 8N1, 7E1 and 8N2 receivers driven by a bit-level line model.
module tb_x_top_uart_rx_cfg;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 10000;
    localparam int P      = CLK_HZ / BAUD;
    localparam int H      = P / 2;

    logic       clk  = 1'b0;
    logic       nrst = 1'b0;
    logic [2:0] rx   = 3'b111;
    logic [2:0] v, pe, fe, bz;
    logic [7:0] d0;
    logic [6:0] d1;
    logic [7:0] d2;

    int checks   = 0;
    int failures = 0;

    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [10:0] q2[$];

    always #5 clk = ~clk;

    x_top_uart_rx_cfg #(.P_CLK_HZ(CLK_HZ), .P_BAUD(BAUD), .P_DATA_BITS(8), .P_PARITY(0), .P_STOP_BITS(1)) u_8n1 (
        .i_clk(clk), .i_nrst(nrst), .i_rx(rx[0]), .o_valid(v[0]), .o_data(d0),
        .o_parity_err(pe[0]), .o_frame_err(fe[0]), .o_busy(bz[0]));
    x_top_uart_rx_cfg #(.P_CLK_HZ(CLK_HZ), .P_BAUD(BAUD), .P_DATA_BITS(7), .P_PARITY(1), .P_STOP_BITS(1)) u_7e1 (
        .i_clk(clk), .i_nrst(nrst), .i_rx(rx[1]), .o_valid(v[1]), .o_data(d1),
        .o_parity_err(pe[1]), .o_frame_err(fe[1]), .o_busy(bz[1]));
    x_top_uart_rx_cfg #(.P_CLK_HZ(CLK_HZ), .P_BAUD(BAUD), .P_DATA_BITS(8), .P_PARITY(0), .P_STOP_BITS(2)) u_8n2 (
        .i_clk(clk), .i_nrst(nrst), .i_rx(rx[2]), .o_valid(v[2]), .o_data(d2),
        .o_parity_err(pe[2]), .o_frame_err(fe[2]), .o_busy(bz[2]));

    // capture every completed frame as {parity_err, frame_err, data}
    always @(negedge clk) begin
        if (v[0]) q0.push_back({pe[0], fe[0], 9'(d0)});
        if (v[1]) q1.push_back({pe[1], fe[1], 9'(d1)});
        if (v[2]) q2.push_back({pe[2], fe[2], 9'(d2)});
    end

    function automatic int nbits(input int i);  return (i == 1) ? 7 : 8; endfunction
    function automatic int pmode(input int i);  return (i == 1) ? 1 : 0; endfunction
    function automatic int nstop(input int i);  return (i == 2) ? 2 : 1; endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
    endfunction

    function automatic logic [8:0] cur_data(input int i);
        return (i == 0) ? 9'(d0) : (i == 1) ? 9'(d1) : 9'(d2);
    endfunction

    // frame outcome from the line-level rules: {parity_err, frame_err, data}
    function automatic logic [10:0] model(input int i, input logic [8:0] d, input logic pbit, input logic [1:0] stop);
        logic [8:0] m;
        int         ones;
        logic       p_err;
        logic       f_err;
        m     = d & 9'((1 << nbits(i)) - 1);
        ones  = $countones(m) + int'(pbit);
        p_err = 1'b0;
        if (pmode(i) == 1) p_err = (ones % 2) != 0;
        if (pmode(i) == 2) p_err = (ones % 2) == 0;
        f_err = !stop[0] || (nstop(i) == 2 && !stop[1]);
        return {p_err, f_err, m};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic b);
        rx[i] = b;
        tick(P);
    endtask

    task automatic send_frame(input int i, input logic [8:0] d, input logic pbit, input logic [1:0] stop);
        drive(i, 1'b0);
        for (int b = 0; b < nbits(i); b++) drive(i, d[b]);
        if (pmode(i) != 0) drive(i, pbit);
        for (int s = 0; s < nstop(i); s++) drive(i, stop[s]);
    endtask

    task automatic expect_frame(input int i, input string nm, input logic [10:0] exp);
        logic [10:0] e;
        if (qsize(i) == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: no o_valid seen, expected data 0x%0h", nm, exp[8:0]);
            return;
        end
        case (i)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        check({nm, " data"}, 32'(e[8:0]), 32'(exp[8:0]));
        check({nm, " perr"}, 32'(e[10]),  32'(exp[10]));
        check({nm, " ferr"}, 32'(e[9]),   32'(exp[9]));
    endtask

    typedef struct {
        int          inst;
        logic [8:0]  data;
        logic        pbit;
        logic [1:0]  stop;
        logic [10:0] exp;   // {parity_err, frame_err, data}
    } vec_t;

    vec_t tbl[8];

    initial begin
        int          budget;
        int          inst;
        logic [8:0]  rd;
        logic        rp;
        logic [1:0]  rs;
        int          gap;

        tbl[0] = '{0, 9'h0A5, 1'b0, 2'b11, {1'b0, 1'b0, 9'h0A5}};
        tbl[1] = '{1, 9'h041, 1'b1, 2'b11, {1'b1, 1'b0, 9'h041}};
        tbl[2] = '{1, 9'h041, 1'b0, 2'b11, {1'b0, 1'b0, 9'h041}};
        tbl[3] = '{1, 9'h07F, 1'b1, 2'b11, {1'b0, 1'b0, 9'h07F}};
        tbl[4] = '{2, 9'h0C3, 1'b0, 2'b01, {1'b0, 1'b1, 9'h0C3}};
        tbl[5] = '{2, 9'h081, 1'b0, 2'b11, {1'b0, 1'b0, 9'h081}};
        tbl[6] = '{0, 9'h05A, 1'b0, 2'b10, {1'b0, 1'b1, 9'h05A}};
        tbl[7] = '{2, 9'h012, 1'b0, 2'b10, {1'b0, 1'b1, 9'h012}};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset valid", 32'(v),  32'd0);
        check("reset busy",  32'(bz), 32'd0);
        check("reset perr",  32'(pe), 32'd0);
        check("reset ferr",  32'(fe), 32'd0);
        check("reset data0", 32'(d0), 32'd0);
        check("reset data1", 32'(d1), 32'd0);
        check("reset data2", 32'(d2), 32'd0);
        @(posedge clk);
        #1 nrst = 1'b1;
        tick(10);

        for (int k = 0; k < 8; k++) begin
            send_frame(tbl[k].inst, tbl[k].data, tbl[k].pbit, tbl[k].stop);
            rx[tbl[k].inst] = 1'b1;
            tick(2 * P);
            check($sformatf("vec%0d count", k), 32'(qsize(tbl[k].inst)), 32'd1);
            expect_frame(tbl[k].inst, $sformatf("vec%0d", k), tbl[k].exp);
            check($sformatf("vec%0d hold", k), 32'(cur_data(tbl[k].inst)), 32'(tbl[k].exp[8:0]));
        end

        // short low glitch while idle
        rx[0] = 1'b0;
        tick(20);
        check("glitch busy", 32'(bz[0]), 32'd1);
        rx[0] = 1'b1;
        budget = 0;
        while (bz[0] && budget < H + 5) begin
            tick(1);
            budget++;
        end
        check("glitch busy clears", 32'(bz[0]), 32'd0);
        tick(2 * P);
        check("glitch no valid", 32'(q0.size()), 32'd0);

        // back-to-back frames, no idle gap
        send_frame(0, 9'h000, 1'b0, 2'b11);
        send_frame(0, 9'h0FF, 1'b0, 2'b11);
        send_frame(0, 9'h055, 1'b0, 2'b11);
        tick(P);
        check("b2b count", 32'(q0.size()), 32'd3);
        expect_frame(0, "b2b 00", {2'b00, 9'h000});
        expect_frame(0, "b2b ff", {2'b00, 9'h0FF});
        expect_frame(0, "b2b 55", {2'b00, 9'h055});

        // break: line held low well beyond one frame
        rx[0] = 1'b0;
        tick(15 * P);
        check("break count", 32'(q0.size()), 32'd1);
        expect_frame(0, "break", {1'b0, 1'b1, 9'h000});
        check("break idle", 32'(bz[0]), 32'd0);
        rx[0] = 1'b1;
        tick(2 * P);
        check("break no retrigger", 32'(q0.size()), 32'd0);

        // reset in the middle of a data field
        drive(0, 1'b0);
        drive(0, 1'b1);
        rx[0] = 1'b0;
        tick(P / 2);
        check("mid-data busy", 32'(bz[0]), 32'd1);
        nrst = 1'b0;
        tick(2);
        check("reset abort busy", 32'(bz[0]), 32'd0);
        rx[0] = 1'b1;
        tick(3);
        nrst = 1'b1;
        tick(P);
        check("reset abort no valid", 32'(q0.size()), 32'd0);
        send_frame(0, 9'h03C, 1'b0, 2'b11);
        tick(P);
        check("post-reset count", 32'(q0.size()), 32'd1);
        expect_frame(0, "post-reset", {2'b00, 9'h03C});

        // randomized frames against the rule-level model
        for (int n = 0; n < 20; n++) begin
            inst = $urandom_range(0, 2);
            rd   = 9'($urandom);
            rp   = 1'($urandom);
            rs   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            send_frame(inst, rd, rp, rs);
            rx[inst] = 1'b1;
            gap = (rs != 2'b11) ? P + $urandom_range(0, 50) :
                  ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 300);
            tick(gap);
            expect_frame(inst, $sformatf("rand%0d", n), model(inst, rd, rp, rs));
        end
        tick(2 * P);
        check("rand leftover", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
